// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> INIT -> ROUND x(NR-1) -> FINAL -> DONE, with registered strobes.
// Optional abort path is compiled in only when AES_CTRL_ABORT_EN is defined.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic       state_sel_init,
    output logic       state_we,
    output logic       key_load,
    output logic       key_we,
    output logic       mc_en,
    output logic [7:0] rcon
);

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic sel_init;
        logic state_we;
        logic key_load;
        logic key_we;
        logic mc_en;
    } strb_t;

    state_t     state;
    strb_t      strb;
    logic [3:0] round_q;
    logic [7:0] rcon_q;
    logic       abort_hit;

    // Strobes are registered from the state being entered, so they line up with it.
    function automatic strb_t decode(input state_t s);
        strb_t d;
        d          = '0;
        d.busy     = (s == INIT) || (s == ROUND) || (s == FINAL);
        d.done     = (s == DONE);
        d.sel_init = (s == INIT);
        d.key_load = (s == INIT);
        d.state_we = (s == INIT) || (s == ROUND) || (s == FINAL);
        d.key_we   = (s == ROUND) || (s == FINAL);
        d.mc_en    = (s == ROUND);
        return d;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef AES_CTRL_ABORT_EN
    assign abort_hit = abort && (state inside {INIT, ROUND, FINAL});
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            strb    <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else if (abort_hit) begin
            state   <= IDLE;
            strb    <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= INIT;
                        strb    <= decode(INIT);
                        round_q <= '0;
                        rcon_q  <= 8'h01;
                    end
                end
                INIT: begin
                    state   <= ROUND;
                    strb    <= decode(ROUND);
                    round_q <= round_q + 4'd1;
                end
                ROUND: begin
                    rcon_q  <= xtime(rcon_q);
                    round_q <= round_q + 4'd1;
                    if (round_q == 4'(NR - 1)) begin
                        state <= FINAL;
                        strb  <= decode(FINAL);
                    end else begin
                        state <= ROUND;
                        strb  <= decode(ROUND);
                    end
                end
                FINAL: begin
                    state <= DONE;
                    strb  <= decode(DONE);
                end
                default: begin
                    state   <= IDLE;
                    strb    <= '0;
                    round_q <= '0;
                    rcon_q  <= 8'h01;
                end
            endcase
        end
    end

    assign busy           = strb.busy;
    assign done           = strb.done;
    assign state_sel_init = strb.sel_init;
    assign state_we       = strb.state_we;
    assign key_load       = strb.key_load;
    assign key_we         = strb.key_we;
    assign mc_en          = strb.mc_en;
    assign round          = round_q;
    assign rcon           = rcon_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl (NR=10): stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the output vector.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, state_sel_init, state_we, key_load, key_we, mc_en;
    logic [3:0] round;
    logic [7:0] rcon;

    aes_round_ctrl #(.NR(10)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .round          (round),
        .state_sel_init (state_sel_init),
        .state_we       (state_we),
        .key_load       (key_load),
        .key_we         (key_we),
        .mc_en          (mc_en),
        .rcon           (rcon)
    );

    always #5 clk = ~clk;

    // {busy, done, sel_init, state_we, key_load, key_we, mc_en, round[3:0], rcon[7:0]}
    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [18:0] act;
    logic [7:0]  rc_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    assign act = {busy, done, state_sel_init, state_we, key_load, key_we, mc_en, round, rcon};

    // Expected outputs in cycle c of a run (c=1 is INIT); c=0 means IDLE.
    function automatic logic [18:0] exp_at(input int c);
        if (c == 0)       return {7'b0000000, 4'd0, 8'h01};
        else if (c == 1)  return {7'b1011100, 4'd0, 8'h01};
        else if (c <= 10) return {7'b1001011, 4'(c - 1), rc_tab[c - 2]};
        else if (c == 11) return {7'b1001010, 4'd10, 8'h36};
        else              return {7'b0100000, 4'd10, 8'h36};
    endfunction

    task automatic push(input string tag, input logic [18:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        sb_q.push_back(e);
    endtask

    // Inputs are already set by the caller; advance one edge and queue what must follow it.
    task automatic step(input string tag, input int c);
        @(posedge clk);
        #1;
        push(tag, exp_at(c));
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (act !== e.vec) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (t=%0t)", e.tag, act, e.vec, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then idle without start.
        step("reset", 0);
        step("reset", 0);
        reset_n = 1'b1;
        step("idle", 0);
        step("idle", 0);

        // Single start pulse: full trace, then done holds for 20 cycles.
        start = 1'b1;
        step("run1_c1", 1);
        start = 1'b0;
        for (int c = 2; c <= 12; c++) step($sformatf("run1_c%0d", c), c);
        for (int i = 0; i < 20; i++) step("run1_hold", 12);

        // Start pulses while busy are ignored.
        start = 1'b1;
        step("run2_c1", 1);
        start = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            start = (c == 4) || (c == 8);
            step($sformatf("run2_c%0d", c), c);
        end
        start = 1'b0;
        step("run2_hold", 12);

        // Start held high through DONE re-enters INIT, extra start during INIT ignored.
        start = 1'b1;
        step("b2b_c1", 1);
        step("b2b_c2", 2);
        start = 1'b0;
        for (int c = 3; c <= 12; c++) step($sformatf("b2b_c%0d", c), c);

        // Async reset mid round 5, then a clean full run.
        start = 1'b1;
        step("rst_c1", 1);
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step($sformatf("rst_c%0d", c), c);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 push("async_rst", exp_at(0));
        step("rst_low", 0);
        reset_n = 1'b1;
        step("rst_rel", 0);
        start = 1'b1;
        step("post_c1", 1);
        start = 1'b0;
        for (int c = 2; c <= 12; c++) step($sformatf("post_c%0d", c), c);

        // Abort during round 4.
        start = 1'b1;
        step("abt_c1", 1);
        start = 1'b0;
        for (int c = 2; c <= 5; c++) step($sformatf("abt_c%0d", c), c);
        abort = 1'b1;
`ifdef AES_CTRL_ABORT_EN
        step("abt_idle", 0);
        abort = 1'b0;
        for (int i = 0; i < 10; i++) step("abt_stay_idle", 0);
`else
        step("abt_c6", 6);
        abort = 1'b0;
        for (int c = 7; c <= 12; c++) step($sformatf("abt_c%0d", c), c);
        // Abort in DONE never has an effect.
        abort = 1'b1;
        step("abt_in_done", 12);
        abort = 1'b0;
        step("abt_in_done2", 12);
`endif

        // Let the monitor drain the queue within a bounded number of cycles.
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES-128 encryption core. It accepts a start pulse, steps the shared round datapath (SubBytes/ShiftRows, mix_columns, AddRoundKey, key expansion) through the initial key addition, NR-1 full rounds and the final round. It drives mix_columns' `enable` low in the final round, supplies the round constant to the key-expansion step, and reports completion through a sticky `done` flag. It sits between the SPI/top-level load logic and the round datapath registers.

## Interface
- `NR`, default 10: number of cipher rounds; legal range 2..14. Only 10 yields FIPS-197 AES-128.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request encryption; sampled only in IDLE or DONE.
- `abort` input 1: synchronous abort; functional only with `AES_CTRL_ABORT_EN`.
- `busy` output 1: high in INIT, ROUND and FINAL.
- `done` output 1: high in DONE; held until the next accepted `start`.
- `round` output 4: current round index, 0..NR.
- `state_sel_init` output 1: state register input mux selects plaintext ^ key (INIT only).
- `state_we` output 1: state register write enable.
- `key_load` output 1: round-key register loads the cipher key (INIT only).
- `key_we` output 1: round-key register loads the expanded key.
- `mc_en` output 1: drives mix_columns `enable`. 1 = mix, 0 = pass-through.
- `rcon` output 8: round constant for the key expansion of the current round.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE. All outputs are Moore, decoded from registered state, `round` and `rcon`.
- IDLE: all strobes 0. `start`=1 leads to INIT.
- INIT: `state_sel_init`=1, `state_we`=1, `key_load`=1, `round`=0. Next state is ROUND.
- ROUND: `state_we`=1, `key_we`=1, `mc_en`=1, `round` runs 1..NR-1. When `round`==NR-1 the next state is FINAL.
- FINAL: `state_we`=1, `key_we`=1, `mc_en`=0, `round`=NR. Next state is DONE.
- DONE: `done`=1, strobes 0, `round` holds NR. `start`=1 leads to INIT and clears `done` on the same edge.
- `round` increments on each transition into ROUND or FINAL and is cleared to 0 on entry to INIT.
- `rcon` rules:
  - Set to 0x01 on entry to INIT.
  - Advanced by xtime on each transition out of ROUND: `rcon`<<1, XOR 0x1B if bit 7 was set.
  - Sequence presented for rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- `start` asserted while busy is ignored; no queuing.
- `mc_en` is 0 in every state except ROUND.
- `reset_n` low, at any time including mid-encryption:
  - State goes to IDLE.
  - `round`=0, `rcon`=0x01.
  - All other outputs 0.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: INIT.
- Cycles 2..NR: ROUND.
- Cycle NR+1: FINAL.
- Cycle NR+2: `done`=1. For NR=10, `done` rises 12 clocks after the `start` edge.
- `busy` is high for exactly NR+1 consecutive cycles per encryption.
- Back-to-back: `start` held high in DONE re-enters INIT on the next edge. `done` falls that same edge.
- Reset values of all outputs are as listed under reset above; `reset_n` release is synchronised externally.

## Configuration
- `AES_CTRL_ABORT_EN` defined:
  - `abort`=1 in INIT, ROUND or FINAL returns the FSM to IDLE on the next edge.
  - `done` stays 0, `round`=0, `rcon`=0x01.
  - `abort` has priority over `start` and over normal advance.
  - `abort` in IDLE or DONE has no effect.
- Not defined: `abort` is ignored (no logic generated); the port remains for a stable interface.

## Test plan
- Reset then single `start` pulse, NR=10 -> `busy` high cycles 1..11; `done` rises at cycle 12 and stays high 20 further cycles with `start` low; `round` trace is 0,1..10.
- Same run, per-cycle check -> `mc_en`=1 only in cycles 2..10; `rcon` in cycles 2..11 equals 01,02,04,08,10,20,40,80,1B,36; `key_load` and `state_sel_init` only in cycle 1.
- `start` pulsed in cycles 3 and 7 of a run -> ignored; `done` still at cycle 12. Then `start` held high through DONE -> INIT next cycle, `done` low, `rcon`=0x01.
- `reset_n` driven low asynchronously mid-cycle during round 5 -> outputs immediately IDLE values (`busy`=0, `round`=0, `rcon`=0x01). A new `start` completes a full 12-cycle run.
- With `AES_CTRL_ABORT_EN`, `abort`=1 at round 4 -> IDLE next edge, `done` never asserts. Without the macro, the same stimulus -> `done` at cycle 12.
- Integration with datapath and mix_columns, FIPS-197 C.1 (key 000102…0f, pt 00112233…ff) -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a when `done`=1.
